// File: rtl/enokida_assoc_cache.sv
// N-way set-associative, write-back / write-allocate data cache between the RI5CY LSU
// and data memory; true-LRU replacement, bypass mode and saturating statistics counters.
module enokida_assoc_cache #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int WAYS       = 4,
    parameter int SET_BITS   = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    proc_cache_data_req_i,
    input  logic [ADDR_WIDTH-1:0]   proc_cache_data_addr_i,
    input  logic                    proc_cache_data_we_i,
    input  logic [DATA_WIDTH/8-1:0] proc_cache_data_be_i,
    input  logic [DATA_WIDTH-1:0]   proc_cache_data_wdata_i,
    output logic                    proc_cache_data_gnt_o,
    output logic                    proc_cache_data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   proc_cache_data_rdata_o,
    input  logic                    cache_mem_data_gnt_i,
    input  logic                    cache_mem_data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   cache_mem_data_rdata_i,
    output logic                    cache_mem_data_req_o,
    output logic [ADDR_WIDTH-1:0]   cache_mem_data_addr_o,
    output logic                    cache_mem_data_we_o,
    output logic [DATA_WIDTH/8-1:0] cache_mem_data_be_o,
    output logic [DATA_WIDTH-1:0]   cache_mem_data_wdata_o,
    input  logic                    cache_enable_i,
    input  logic                    counters_clear_i,
    output logic [CNT_WIDTH-1:0]    access_count_o,
    output logic [CNT_WIDTH-1:0]    hit_count_o,
    output logic [CNT_WIDTH-1:0]    miss_count_o,
    output logic [CNT_WIDTH-1:0]    writeback_count_o
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BE_W);
    localparam int SETS  = 1 << SET_BITS;
    localparam int TAG_W = ADDR_WIDTH - SET_BITS - OFF;
    localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_LOOKUP, S_WB_REQ, S_WB_WAIT, S_FILL_REQ, S_FILL_WAIT,
        S_BYP_REQ, S_BYP_WAIT, S_RESP
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [BE_W-1:0]       be_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [WW-1:0]         way_q;
    logic [CNT_WIDTH-1:0]  acc_q, hit_q, miss_q, wb_q;

    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       dirty_q [SETS];
    logic [WW-1:0]         age_q   [SETS][WAYS];
    logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];

    logic [SET_BITS-1:0]   idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit, found_inv, lru_en, dwr_en, fill_done;
    logic [WW-1:0]         hit_way, vict_way, lru_way, dwr_way;
    logic [DATA_WIDTH-1:0] dwr_data;

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                    input logic [DATA_WIDTH-1:0] new_w,
                                                    input logic [BE_W-1:0] be);
        merge = old_w;
        for (int b = 0; b < BE_W; b++)
            if (be[b]) merge[8*b +: 8] = new_w[8*b +: 8];
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic inc);
        return (inc && !(&c)) ? c + CNT_WIDTH'(1) : c;
    endfunction

    assign idx = addr_q[OFF +: SET_BITS];
    assign tag = addr_q[ADDR_WIDTH-1 -: TAG_W];

    // Victim: lowest-numbered invalid way, otherwise the way whose age is WAYS-1.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        vict_way  = '0;
        found_inv = 1'b0;
        for (int w = 0; w < WAYS; w++)
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid_q[idx][w]) begin
                found_inv = 1'b1;
                vict_way  = WW'(w);
            end
        if (!found_inv)
            for (int w = 0; w < WAYS; w++)
                if (age_q[idx][w] == WW'(WAYS - 1)) vict_way = WW'(w);
    end

    assign fill_done = (state_q == S_FILL_WAIT) && cache_mem_data_rvalid_i;
    assign lru_en    = ((state_q == S_LOOKUP) && hit) || fill_done;
    assign lru_way   = (state_q == S_LOOKUP) ? hit_way : way_q;

    always_comb begin
        dwr_en   = 1'b0;
        dwr_way  = way_q;
        dwr_data = cache_mem_data_rdata_i;
        if ((state_q == S_LOOKUP) && hit && we_q) begin
            dwr_en   = 1'b1;
            dwr_way  = hit_way;
            dwr_data = merge(data_q[idx][hit_way], wdata_q, be_q);
        end else if (fill_done) begin
            dwr_en   = 1'b1;
            dwr_data = we_q ? merge(cache_mem_data_rdata_i, wdata_q, be_q) : cache_mem_data_rdata_i;
        end
    end

    always_comb begin
        state_d                = state_q;
        proc_cache_data_gnt_o  = proc_cache_data_req_i && (state_q == S_IDLE);
        cache_mem_data_req_o   = 1'b0;
        cache_mem_data_addr_o  = '0;
        cache_mem_data_we_o    = 1'b0;
        cache_mem_data_be_o    = '0;
        cache_mem_data_wdata_o = '0;
        unique case (state_q)
            S_IDLE:      if (proc_cache_data_gnt_o) state_d = cache_enable_i ? S_LOOKUP : S_BYP_REQ;
            S_LOOKUP: begin
                if (hit)                                            state_d = S_RESP;
                else if (valid_q[idx][vict_way] && dirty_q[idx][vict_way]) state_d = S_WB_REQ;
                else                                                state_d = S_FILL_REQ;
            end
            S_WB_REQ: begin
                cache_mem_data_req_o   = 1'b1;
                cache_mem_data_we_o    = 1'b1;
                cache_mem_data_be_o    = '1;
                cache_mem_data_addr_o  = ADDR_WIDTH'({tag_q[idx][way_q], idx}) << OFF;
                cache_mem_data_wdata_o = data_q[idx][way_q];
                if (cache_mem_data_gnt_i) state_d = S_WB_WAIT;
            end
            S_WB_WAIT:   if (cache_mem_data_rvalid_i) state_d = S_FILL_REQ;
            S_FILL_REQ: begin
                cache_mem_data_req_o  = 1'b1;
                cache_mem_data_be_o   = '1;
                cache_mem_data_addr_o = ADDR_WIDTH'({tag, idx}) << OFF;
                if (cache_mem_data_gnt_i) state_d = S_FILL_WAIT;
            end
            S_FILL_WAIT: if (cache_mem_data_rvalid_i) state_d = S_RESP;
            S_BYP_REQ: begin
                cache_mem_data_req_o   = 1'b1;
                cache_mem_data_we_o    = we_q;
                cache_mem_data_be_o    = be_q;
                cache_mem_data_addr_o  = addr_q;
                cache_mem_data_wdata_o = wdata_q;
                if (cache_mem_data_gnt_i) state_d = S_BYP_WAIT;
            end
            S_BYP_WAIT:  if (cache_mem_data_rvalid_i) state_d = S_RESP;
            S_RESP:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Tag and data arrays need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (dwr_en)    data_q[idx][dwr_way] <= dwr_data;
        if (fill_done) tag_q[idx][way_q]    <= tag;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            way_q   <= '0;
            acc_q   <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
            wb_q    <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= WW'(w);
            end
        end else begin
            state_q <= state_d;
            if (proc_cache_data_gnt_o) begin
                addr_q  <= proc_cache_data_addr_i;
                we_q    <= proc_cache_data_we_i;
                be_q    <= proc_cache_data_be_i;
                wdata_q <= proc_cache_data_wdata_i;
            end
            if (lru_en)
                for (int v = 0; v < WAYS; v++)
                    if (WW'(v) == lru_way)                    age_q[idx][v] <= '0;
                    else if (age_q[idx][v] < age_q[idx][lru_way]) age_q[idx][v] <= age_q[idx][v] + WW'(1);
            unique case (state_q)
                S_LOOKUP: begin
                    way_q <= hit ? hit_way : vict_way;
                    if (hit) begin
                        rdata_q <= we_q ? '0 : data_q[idx][hit_way];
                        if (we_q) dirty_q[idx][hit_way] <= 1'b1;
                    end
                end
                S_WB_WAIT:   if (cache_mem_data_rvalid_i) dirty_q[idx][way_q] <= 1'b0;
                S_FILL_WAIT: if (cache_mem_data_rvalid_i) begin
                    valid_q[idx][way_q] <= 1'b1;
                    dirty_q[idx][way_q] <= we_q;
                    rdata_q             <= we_q ? '0 : cache_mem_data_rdata_i;
                end
                S_BYP_WAIT:  if (cache_mem_data_rvalid_i) rdata_q <= we_q ? '0 : cache_mem_data_rdata_i;
                S_RESP:      rdata_q <= '0;
                default: ;
            endcase
            if (counters_clear_i) begin
                acc_q  <= '0;
                hit_q  <= '0;
                miss_q <= '0;
                wb_q   <= '0;
            end else begin
                acc_q  <= sat_inc(acc_q, proc_cache_data_gnt_o);
                hit_q  <= sat_inc(hit_q, (state_q == S_LOOKUP) && hit);
                miss_q <= sat_inc(miss_q, (state_q == S_LOOKUP) && !hit);
                wb_q   <= sat_inc(wb_q, (state_q == S_LOOKUP) && (state_d == S_WB_REQ));
            end
        end
    end

    assign proc_cache_data_rvalid_o = (state_q == S_RESP);
    assign proc_cache_data_rdata_o  = rdata_q;
    assign access_count_o           = acc_q;
    assign hit_count_o              = hit_q;
    assign miss_count_o             = miss_q;
    assign writeback_count_o        = wb_q;
endmodule
